// File: rtl/video_timing_out_if.sv
// ============================================================================
//  Module      : video_timing_out_if
//  Description : Colour-in / RGB888-plus-sync-out bundle of the video output stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface video_timing_out_if;
    logic [15:0] color_wd;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic        de;
    logic        hs_o;
    logic        vs_o;
    logic        cs_o;

    modport master (
        input  color_wd,
        output r8, g8, b8, de, hs_o, vs_o, cs_o
    );

    modport slave (
        output color_wd,
        input  r8, g8, b8, de, hs_o, vs_o, cs_o
    );
endinterface

`default_nettype wire

// File: rtl/video_timing_out.sv
// ============================================================================
//  Module      : video_timing_out
//  Description : Pixel-rate raster counters/decodes plus the 1BGR555 -> RGB888
//                output register; optional vblank IRQ via VIDOUT_VBL_IRQ_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module video_timing_out #(
    parameter int H_TOTAL    = 384,
    parameter int H_ACTIVE   = 288,
    parameter int H_SYNC_ST  = 312,
    parameter int H_SYNC_LEN = 32,
    parameter int V_TOTAL    = 264,
    parameter int V_ACTIVE   = 224,
    parameter int V_SYNC_ST  = 240,
    parameter int V_SYNC_LEN = 8,
    parameter int PIPE_DLY   = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    video_timing_out_if.master     vid,
    output logic [8:0]             hcnt,
    output logic [8:0]             vcnt,
    output logic                   nhbk,
    output logic                   nvbk,
    output logic                   cblk,
    output logic                   nhsy,
    output logic                   nvsy,
    output logic                   nirq,
    input  wire logic              irq_ack
);

    localparam logic [8:0] c_h_last     = 9'(H_TOTAL - 1);
    localparam logic [8:0] c_v_last     = 9'(V_TOTAL - 1);
    localparam logic [8:0] c_h_active   = 9'(H_ACTIVE);
    localparam logic [8:0] c_v_active   = 9'(V_ACTIVE);
    localparam logic [8:0] c_h_sync_st  = 9'(H_SYNC_ST);
    localparam logic [8:0] c_h_sync_end = 9'(H_SYNC_ST + H_SYNC_LEN);
    localparam logic [8:0] c_v_sync_st  = 9'(V_SYNC_ST);
    localparam logic [8:0] c_v_sync_end = 9'(V_SYNC_ST + V_SYNC_LEN);

    logic       w_h_wrap;
    logic [8:0] w_hcnt_nxt;
    logic [8:0] w_vcnt_nxt;
    logic       w_nhbk_nxt;
    logic       w_nvbk_nxt;
    logic       w_nhsy_nxt;
    logic       w_nvsy_nxt;

    // Decodes are taken from the next counter values so that, once registered,
    // they line up with the counter value they describe.
    always_comb begin
        w_h_wrap   = (hcnt == c_h_last);
        w_hcnt_nxt = w_h_wrap ? 9'd0 : hcnt + 9'd1;
        w_vcnt_nxt = vcnt;
        if (w_h_wrap) begin
            w_vcnt_nxt = (vcnt == c_v_last) ? 9'd0 : vcnt + 9'd1;
        end
        w_nhbk_nxt = (w_hcnt_nxt < c_h_active);
        w_nvbk_nxt = (w_vcnt_nxt < c_v_active);
        w_nhsy_nxt = !((w_hcnt_nxt >= c_h_sync_st) && (w_hcnt_nxt < c_h_sync_end));
        w_nvsy_nxt = !((w_vcnt_nxt >= c_v_sync_st) && (w_vcnt_nxt < c_v_sync_end));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= 9'd0;
            vcnt <= 9'd0;
            nhbk <= 1'b1;
            nvbk <= 1'b1;
            cblk <= 1'b1;
            nhsy <= 1'b1;
            nvsy <= 1'b1;
        end else begin
            hcnt <= w_hcnt_nxt;
            vcnt <= w_vcnt_nxt;
            nhbk <= w_nhbk_nxt;
            nvbk <= w_nvbk_nxt;
            cblk <= w_nhbk_nxt & w_nvbk_nxt;
            nhsy <= w_nhsy_nxt;
            nvsy <= w_nvsy_nxt;
        end
    end

    logic [PIPE_DLY-1:0] r_hs_pipe;
    logic [PIPE_DLY-1:0] r_vs_pipe;
    logic                w_vis;
    logic [4:0]          w_r5;
    logic [4:0]          w_g5;
    logic [4:0]          w_b5;

    assign w_vis = vid.color_wd[15];
    assign w_b5  = vid.color_wd[14:10];
    assign w_g5  = vid.color_wd[9:5];
    assign w_r5  = vid.color_wd[4:0];

    // Sync walks the same number of stages as the mixer so it meets its pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_pipe <= '1;
            r_vs_pipe <= '1;
            vid.r8    <= 8'h00;
            vid.g8    <= 8'h00;
            vid.b8    <= 8'h00;
            vid.de    <= 1'b0;
            vid.hs_o  <= 1'b1;
            vid.vs_o  <= 1'b1;
            vid.cs_o  <= 1'b1;
        end else begin
            r_hs_pipe[0] <= nhsy;
            r_vs_pipe[0] <= nvsy;
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
            end
            vid.de   <= w_vis;
            vid.r8   <= w_vis ? {w_r5, w_r5[4:2]} : 8'h00;
            vid.g8   <= w_vis ? {w_g5, w_g5[4:2]} : 8'h00;
            vid.b8   <= w_vis ? {w_b5, w_b5[4:2]} : 8'h00;
            vid.hs_o <= r_hs_pipe[PIPE_DLY-1];
            vid.vs_o <= r_vs_pipe[PIPE_DLY-1];
            vid.cs_o <= r_hs_pipe[PIPE_DLY-1] & r_vs_pipe[PIPE_DLY-1];
        end
    end

`ifdef VIDOUT_VBL_IRQ_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       w_set;

    assign w_set = (vcnt == c_v_active) && (hcnt == 9'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A set event outranks a simultaneous acknowledge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_set) w_state_nxt = S_PEND;
            S_PEND:  if (!w_set && irq_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        nirq = 1'b1;
        if (r_state == S_PEND) nirq = 1'b0;
    end
`else
    logic w_unused_irq_ack;
    assign w_unused_irq_ack = irq_ack;
    assign nirq = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_timing_out.sv
// ============================================================================
//  Module      : tb_video_timing_out
//  Description : Self-checking bench for video_timing_out (full-size and
//                reduced-raster instances).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_timing_out;

    localparam int HT  [2] = '{384, 24};
    localparam int HA  [2] = '{288, 16};
    localparam int HSS [2] = '{312, 18};
    localparam int HSL [2] = '{32, 3};
    localparam int VT  [2] = '{264, 12};
    localparam int VA  [2] = '{224, 8};
    localparam int VSS [2] = '{240, 9};
    localparam int VSL [2] = '{8, 2};

    logic       clk;
    logic       rst;
    logic [8:0] hcnt [2];
    logic [8:0] vcnt [2];
    logic       nhbk [2];
    logic       nvbk [2];
    logic       cblk [2];
    logic       nhsy [2];
    logic       nvsy [2];
    logic       nirq [2];
    logic       ack  [2];

    video_timing_out_if ifc0 ();
    video_timing_out_if ifc1 ();

    video_timing_out u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .vid     (ifc0),
        .hcnt    (hcnt[0]),
        .vcnt    (vcnt[0]),
        .nhbk    (nhbk[0]),
        .nvbk    (nvbk[0]),
        .cblk    (cblk[0]),
        .nhsy    (nhsy[0]),
        .nvsy    (nvsy[0]),
        .nirq    (nirq[0]),
        .irq_ack (ack[0])
    );

    video_timing_out #(
        .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_ST(18), .H_SYNC_LEN(3),
        .V_TOTAL(12), .V_ACTIVE(8), .V_SYNC_ST(9), .V_SYNC_LEN(2), .PIPE_DLY(2)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .vid     (ifc1),
        .hcnt    (hcnt[1]),
        .vcnt    (vcnt[1]),
        .nhbk    (nhbk[1]),
        .nvbk    (nvbk[1]),
        .cblk    (cblk[1]),
        .nhsy    (nhsy[1]),
        .nvsy    (nvsy[1]),
        .nirq    (nirq[1]),
        .irq_ack (ack[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h at t=%0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- reference raster model ----------------
    int         mh [2];
    int         mv [2];
    logic [2:0] hp [2];
    logic [2:0] vp [2];
    logic       pend [2];

    function automatic logic f_nhsy(input int k, input int h);
        return !((h >= HSS[k]) && (h < HSS[k] + HSL[k]));
    endfunction

    function automatic logic f_nvsy(input int k, input int v);
        return !((v >= VSS[k]) && (v < VSS[k] + VSL[k]));
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mh[k]   <= 0;
                mv[k]   <= 0;
                hp[k]   <= 3'b111;
                vp[k]   <= 3'b111;
                pend[k] <= 1'b0;
            end else begin
                hp[k] <= {hp[k][1:0], f_nhsy(k, mh[k])};
                vp[k] <= {vp[k][1:0], f_nvsy(k, mv[k])};
                if (mv[k] == VA[k] && mh[k] == 0) pend[k] <= 1'b1;
                else if (ack[k])                  pend[k] <= 1'b0;
                if (mh[k] == HT[k] - 1) begin
                    mh[k] <= 0;
                    mv[k] <= (mv[k] == VT[k] - 1) ? 0 : mv[k] + 1;
                end else begin
                    mh[k] <= mh[k] + 1;
                end
            end
        end
    end

    task automatic chk_timing(input int k, input logic [8:0] h, input logic [8:0] v,
                              input logic hb, input logic vb, input logic cb,
                              input logic hs, input logic vs, input logic hso,
                              input logic vso, input logic cso, input logic ni);
        logic e_hb, e_vb, e_ni;
        e_hb = (mh[k] < HA[k]);
        e_vb = (mv[k] < VA[k]);
`ifdef VIDOUT_VBL_IRQ_EN
        e_ni = !pend[k];
`else
        e_ni = 1'b1;
`endif
        check("hcnt", k, 32'(h), 32'(mh[k]));
        check("vcnt", k, 32'(v), 32'(mv[k]));
        check("nhbk", k, 32'(hb), 32'(e_hb));
        check("nvbk", k, 32'(vb), 32'(e_vb));
        check("cblk", k, 32'(cb), 32'(e_hb & e_vb));
        check("nhsy", k, 32'(hs), 32'(f_nhsy(k, mh[k])));
        check("nvsy", k, 32'(vs), 32'(f_nvsy(k, mv[k])));
        check("hs_o", k, 32'(hso), 32'(hp[k][2]));
        check("vs_o", k, 32'(vso), 32'(vp[k][2]));
        check("cs_o", k, 32'(cso), 32'(hp[k][2] & vp[k][2]));
        check("nirq", k, 32'(ni), 32'(e_ni));
    endtask

    always @(negedge clk) begin
        if (!$isunknown(rst)) begin
            chk_timing(0, hcnt[0], vcnt[0], nhbk[0], nvbk[0], cblk[0], nhsy[0], nvsy[0],
                       ifc0.hs_o, ifc0.vs_o, ifc0.cs_o, nirq[0]);
            chk_timing(1, hcnt[1], vcnt[1], nhbk[1], nvbk[1], cblk[1], nhsy[1], nvsy[1],
                       ifc1.hs_o, ifc1.vs_o, ifc1.cs_o, nirq[1]);
        end
    end

    // ---------------- colour scoreboard ----------------
    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        int         stamp;
    } exp_t;

    typedef struct {
        logic [15:0] cw;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        de;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [13];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].stamp < cyc) begin
            e = sb.pop_front();
            check("r8", 0, 32'(ifc0.r8), 32'(e.r));
            check("g8", 0, 32'(ifc0.g8), 32'(e.g));
            check("b8", 0, 32'(ifc0.b8), 32'(e.b));
            check("de", 0, 32'(ifc0.de), 32'(e.de));
        end
    end

    task automatic push_exp(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic de);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.de = de; e.stamp = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_at(input int k, input int v, input int h, input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (hcnt[k] == 9'(h) && vcnt[k] == 9'(v)) found = 1'b1;
        end
        check("wait_timeout", k, 32'(found), 32'd1);
    endtask

    task automatic pulse_ack(input int k);
        @(posedge clk); #2;
        ack[k] = 1'b1;
        @(posedge clk); #2;
        ack[k] = 1'b0;
    endtask

    initial begin
        int n;
        logic found;

        vecs[0]  = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[1]  = '{16'h7FFF, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{16'h8210, 8'h84, 8'h84, 8'h00, 1'b1};
        vecs[3]  = '{16'h8000, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{16'h801F, 8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{16'h83E0, 8'h00, 8'hFF, 8'h00, 1'b1};
        vecs[6]  = '{16'hFC00, 8'h00, 8'h00, 8'hFF, 1'b1};
        vecs[7]  = '{16'h8421, 8'h08, 8'h08, 8'h08, 1'b1};
        vecs[8]  = '{16'hD6B5, 8'hAD, 8'hAD, 8'hAD, 1'b1};
        vecs[9]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{16'h8C63, 8'h18, 8'h18, 8'h18, 1'b1};
        vecs[11] = '{16'h4210, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1};

        rst = 1'b0;
        ack[0] = 1'b0;
        ack[1] = 1'b0;
        ifc0.color_wd = 16'h0000;
        ifc1.color_wd = 16'h0000;
        #1 rst = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check("rst_hcnt", 0, 32'(hcnt[0]), 32'd0);
        check("rst_vcnt", 0, 32'(vcnt[0]), 32'd0);
        check("rst_r8",   0, 32'(ifc0.r8), 32'd0);
        check("rst_de",   0, 32'(ifc0.de), 32'd0);
        check("rst_cs_o", 0, 32'(ifc0.cs_o), 32'd1);
        check("rst_nirq", 0, 32'(nirq[0]), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #2;
            ifc0.color_wd = vecs[i].cw;
            push_exp(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].de);
        end
        @(posedge clk); #2;
        ifc0.color_wd = 16'h0000;
        repeat (4) @(negedge clk);
        check("sb_drained", 0, 32'(sb.size()), 32'd0);

        // frame length on the reduced raster
        wait_at(1, 0, 0, 1000);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            n++;
            if (hcnt[1] == 9'd0 && vcnt[1] == 9'd0) found = 1'b1;
        end
        check("frame_cycles", 1, 32'(n), 32'(HT[1] * VT[1]));

`ifdef VIDOUT_VBL_IRQ_EN
        wait_at(1, VA[1], 0, 1000);
        check("nirq_before_set", 1, 32'(nirq[1]), 32'd1);
        @(negedge clk);
        check("nirq_set", 1, 32'(nirq[1]), 32'd0);
        repeat (99) @(negedge clk);
        check("nirq_pending", 1, 32'(nirq[1]), 32'd0);
        pulse_ack(1);
        check("nirq_acked", 1, 32'(nirq[1]), 32'd1);

        wait_at(1, VA[1], 0, 1000);
        wait_at(1, 0, 5, 1000);
        check("nirq_hold_wrap", 1, 32'(nirq[1]), 32'd0);
        pulse_ack(1);
        check("nirq_acked2", 1, 32'(nirq[1]), 32'd1);

        wait_at(1, VA[1] - 1, HT[1] - 1, 1000);
        @(posedge clk); #2;
        ack[1] = 1'b1;
        @(posedge clk); #2;
        ack[1] = 1'b0;
        check("nirq_set_wins", 1, 32'(nirq[1]), 32'd0);
        pulse_ack(1);
        check("nirq_acked3", 1, 32'(nirq[1]), 32'd1);
        pulse_ack(1);
        check("nirq_idle_ack", 1, 32'(nirq[1]), 32'd1);
`endif

        // mid-frame reset on the full-size raster
        wait_at(0, 100, 149, 60000);
        @(posedge clk); #2;
        ifc0.color_wd = 16'hFFFF;
        rst = 1'b1;
        #1;
        check("mid_rst_hcnt", 0, 32'(hcnt[0]), 32'd0);
        check("mid_rst_vcnt", 0, 32'(vcnt[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_r8",   0, 32'(ifc0.r8), 32'd0);
            check("mid_rst_hs_o", 0, 32'(ifc0.hs_o), 32'd1);
            check("mid_rst_vs_o", 0, 32'(ifc0.vs_o), 32'd1);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        push_exp(8'hFF, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #2;
        ifc0.color_wd = 16'h0000;
        check("restart_hcnt", 0, 32'(hcnt[0]), 32'd1);
        wait_at(0, 1, 350, 1000);

        check("sb_final", 0, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
